// File: rtl/activation_streamer.sv
// -----------------------------------------------------------------------------
// activation_streamer
//
// Source end of the accelerator activation interface. The host loads one N x N
// image into an internal buffer while the block is idle, then pulses start.
// The image is streamed in raster order, one pixel per cycle, on
// activation/ce. After the last pixel, ce stays high with activation = 0 until
// the accelerator raises end_op. A one-cycle done pulse then closes the frame.
// If end_op does not arrive within DRAIN_MAX drain cycles, the frame closes
// anyway and the sticky timeout flag is set. The next accepted start clears it.
//
// Optional feature (macro STREAMER_PAUSE_EN): adds a pause input. While pause
// is high in STREAM or DRAIN, ce drops and the pixel index, drain counter and
// activation are all frozen.
//
// Ports
//   clk         in   1    clock, rising edge
//   global_rst  in   1    asynchronous active-low reset
//   wr_en       in   1    host buffer write strobe (honoured only when idle)
//   wr_addr     in   AW   host write address, raster index 0..N*N-1
//   wr_data     in   DW   host write data
//   start       in   1    begin streaming (honoured only when idle)
//   end_op      in   1    accelerator end-of-frame flag (used only in drain)
//   pause       in   1    freeze streaming (only with STREAMER_PAUSE_EN)
//   activation  out  DW   pixel to accelerator
//   ce          out  1    accelerator clock enable / pixel valid
//   busy        out  1    high while streaming or draining
//   done        out  1    one-cycle pulse when the frame completes
//   timeout     out  1    sticky drain-timeout flag
// -----------------------------------------------------------------------------
module activation_streamer #(
    parameter int N         = 10,
    parameter int DW        = 16,
    parameter int AW        = 7,
    parameter int DRAIN_MAX = 255
) (
    input  logic          clk,
    input  logic          global_rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    input  logic          end_op,
`ifdef STREAMER_PAUSE_EN
    input  logic          pause,
`endif
    output logic [DW-1:0] activation,
    output logic          ce,
    output logic          busy,
    output logic          done,
    output logic          timeout
);

    localparam int NPIX = N * N;
    localparam int CW   = $clog2(DRAIN_MAX + 1);

    localparam logic [AW-1:0] LAST_IDX   = AW'(NPIX - 1);
    localparam logic [AW:0]   NPIX_EXT   = (AW + 1)'(NPIX);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   drain_q, drain_d;
    logic            timeout_q, timeout_d;
    logic [DW-1:0]   act_p0;
    logic            act_ld;
    logic [AW-1:0]   rd_addr;
    logic [DW-1:0]   rd_data;
    logic            rd_ok;
    logic            wr_ok;
    logic            hold;

    logic [DW-1:0]   mem [NPIX];

`ifdef STREAMER_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    // Host writes land only while idle; out-of-range addresses are dropped.
    // Address checks are done one bit wider so 2**AW == N*N still works.
    assign wr_ok = wr_en && (state_q == ST_IDLE) && ({1'b0, wr_addr} < NPIX_EXT);
    assign rd_ok = ({1'b0, rd_addr} < NPIX_EXT);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read data for the next pixel. A write in the start cycle to the address
    // being fetched is forwarded, so the new value is what gets streamed.
    always_comb begin
        rd_data = '0;
        if (rd_ok) begin
            rd_data = mem[rd_addr];
        end
        if (wr_ok && (wr_addr == rd_addr)) begin
            rd_data = wr_data;
        end
    end

    // Next-state logic. idx_q is the index of the pixel currently presented.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        drain_d   = drain_q;
        timeout_d = timeout_q;
        rd_addr   = idx_q + AW'(1);
        act_ld    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                rd_addr = '0;
                if (start) begin
                    state_d   = ST_STREAM;
                    idx_d     = '0;
                    timeout_d = 1'b0;
                    act_ld    = 1'b1;
                end
            end
            ST_STREAM: begin
                if (!hold) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DRAIN;
                        drain_d = '0;
                    end else begin
                        idx_d  = idx_q + AW'(1);
                        act_ld = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // end_op takes priority over the timeout on the same cycle.
                if (end_op) begin
                    state_d = ST_DONE;
                end else if (!hold) begin
                    if (drain_q == DRAIN_LAST) begin
                        state_d   = ST_DONE;
                        timeout_d = 1'b1;
                    end else begin
                        drain_d = drain_q + CW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Stage p0: registered pixel fetch plus control state
    always_ff @(posedge clk or negedge global_rst) begin
        if (!global_rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            drain_q   <= '0;
            timeout_q <= 1'b0;
            act_p0    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            drain_q   <= drain_d;
            timeout_q <= timeout_d;
            if (act_ld) begin
                act_p0 <= rd_data;
            end
        end
    end

    // Outputs decode straight from state so reset drops ce without a clock.
    assign busy       = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
    assign ce         = busy && !hold;
    assign done       = (state_q == ST_DONE);
    assign timeout    = timeout_q;
    assign activation = (state_q == ST_STREAM) ? act_p0 : '0;

endmodule

// File: tb/tb_activation_streamer.sv
// -----------------------------------------------------------------------------
// Bench for activation_streamer (N=10, DW=16, AW=7, DRAIN_MAX=255).
// Stimulus pushes the expected per-cycle output word for every cycle of a frame
// into a scoreboard queue; a negedge monitor pops and compares. With an empty
// queue the monitor expects the block to be quiet (ce, busy, done low).
// -----------------------------------------------------------------------------
module tb_activation_streamer;

    typedef struct packed {
        logic        ce;
        logic        busy;
        logic        done;
        logic        to;
        logic [15:0] act;
    } ent_t;

    typedef struct {
        ent_t  e;
        int    j;
        string name;
    } sb_t;

    logic        clk;
    logic        global_rst;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [15:0] wr_data;
    logic        start;
    logic        end_op;
`ifdef STREAMER_PAUSE_EN
    logic        pause;
`endif
    logic [15:0] activation;
    logic        ce;
    logic        busy;
    logic        done;
    logic        timeout;

    int          tests;
    int          fails;
    sb_t         sb[$];
    logic [15:0] exp_px [100];

    activation_streamer #(
        .N(10), .DW(16), .AW(7), .DRAIN_MAX(255)
    ) dut (
        .clk        (clk),
        .global_rst (global_rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .end_op     (end_op),
`ifdef STREAMER_PAUSE_EN
        .pause      (pause),
`endif
        .activation (activation),
        .ce         (ce),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int tag, input ent_t got, input ent_t want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s cycle %0d: got ce=%b busy=%b done=%b timeout=%b act=%h, want ce=%b busy=%b done=%b timeout=%b act=%h",
                     name, tag, got.ce, got.busy, got.done, got.to, got.act,
                     want.ce, want.busy, want.done, want.to, want.act);
        end
    endtask

    // Monitor: one comparison per negedge.
    always @(negedge clk) begin
        sb_t  s;
        ent_t got;
        if (sb.size() > 0) begin
            s   = sb.pop_front();
            got = '{ce: ce, busy: busy, done: done, to: timeout, act: activation};
            check(s.name, s.j, got, s.e);
        end else begin
            got = '{ce: ce, busy: busy, done: done, to: 1'b0, act: 16'h0};
            check("idle", -1, got, '0);
        end
    end

    // Expected output word for cycle j after the start edge.
    // S = stream cycles (100 + pause length), D = drain cycles.
    function automatic ent_t exp_at(input int j, input int s_len, input int d_len,
                                    input int pl, input bit to);
        ent_t e;
        e = '0;
        if (j < s_len) begin
            e.ce   = 1'b1;
            e.busy = 1'b1;
            if (pl > 0 && j >= 20 && j < 20 + pl) begin
                e.ce  = 1'b0;
                e.act = exp_px[20];
            end else if (pl > 0 && j >= 20 + pl) begin
                e.act = exp_px[j - pl];
            end else begin
                e.act = exp_px[j];
            end
        end else if (j < s_len + d_len) begin
            e.ce   = 1'b1;
            e.busy = 1'b1;
        end else begin
            e.done = (j == s_len + d_len);
            e.to   = to;
        end
        return e;
    endfunction

    // eop_at: drain cycle (0-based) in which end_op is raised, -1 for none.
    // abort_at: stream cycle at which reset is pulsed mid-cycle, -1 for none.
    // disturb: at stream cycle 10 raise start, wr_en(50, BEEF) and end_op.
    // pl: pause length starting at pixel 20 (0 = none).
    task automatic run_frame(input string name, input int eop_at, input int abort_at,
                             input bit disturb, input int pl, input bit wr_at_start,
                             input logic [6:0] ws_addr, input logic [15:0] ws_data);
        int   s_len;
        int   d_len;
        int   total;
        sb_t  s;
        ent_t got;
        s_len = 100 + pl;
        d_len = (eop_at < 0) ? 255 : eop_at + 1;
        total = s_len + d_len + 2;
        start = 1'b1;
        if (wr_at_start) begin
            wr_en   = 1'b1;
            wr_addr = ws_addr;
            wr_data = ws_data;
            exp_px[ws_addr] = ws_data;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_en = 1'b0;
        for (int j = 0; j < total; j++) begin
            s.e    = exp_at(j, s_len, d_len, pl, eop_at < 0);
            s.j    = j;
            s.name = name;
            sb.push_back(s);
            end_op  = (eop_at >= 0 && j == s_len + eop_at) || (disturb && j == 10);
            start   = disturb && j == 10;
            wr_en   = disturb && j == 10;
            wr_addr = 7'd50;
            wr_data = 16'hBEEF;
`ifdef STREAMER_PAUSE_EN
            pause   = (pl > 0 && j >= 20 && j < 20 + pl);
`endif
            if (j == abort_at) begin
                @(negedge clk);
                #2;
                global_rst = 1'b0;
                #1;
                got = '{ce: ce, busy: busy, done: done, to: timeout, act: activation};
                check({name, "_async_rst"}, j, got, '0);
                sb.delete();
                end_op = 1'b0;
                start  = 1'b0;
                wr_en  = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                global_rst = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
        end
        end_op = 1'b0;
        start  = 1'b0;
        wr_en  = 1'b0;
`ifdef STREAMER_PAUSE_EN
        pause  = 1'b0;
`endif
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s_sb_empty: %0d entries left, want 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        ent_t got;
        tests      = 0;
        fails      = 0;
        global_rst = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        start      = 1'b0;
        end_op     = 1'b0;
`ifdef STREAMER_PAUSE_EN
        pause      = 1'b0;
`endif
        #3;
        got = '{ce: ce, busy: busy, done: done, to: timeout, act: activation};
        check("reset_state", 0, got, '0);
        repeat (2) @(posedge clk);
        #1;
        global_rst = 1'b1;

        // Load value = index, with end_op held high while idle.
        end_op = 1'b1;
        for (int i = 0; i < 100; i++) begin
            wr_en     = 1'b1;
            wr_addr   = 7'(i);
            wr_data   = 16'(i);
            exp_px[i] = 16'(i);
            @(posedge clk);
            #1;
        end
        wr_en  = 1'b0;
        end_op = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        run_frame("basic",       0,  -1, 1'b0, 0, 1'b0, 7'd0, 16'h0);
        run_frame("drain12",     12, -1, 1'b0, 0, 1'b0, 7'd0, 16'h0);
        run_frame("timeout",     -1, -1, 1'b0, 0, 1'b0, 7'd0, 16'h0);
        run_frame("to_clear",    3,  -1, 1'b0, 0, 1'b0, 7'd0, 16'h0);
        run_frame("busy_ignore", 2,  -1, 1'b1, 0, 1'b0, 7'd0, 16'h0);
        run_frame("abort",       0,  40, 1'b0, 0, 1'b0, 7'd0, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        run_frame("after_rst",   1,  -1, 1'b0, 0, 1'b0, 7'd0, 16'h0);
        run_frame("eop_at_max",  254, -1, 1'b0, 0, 1'b0, 7'd0, 16'h0);
        run_frame("wr_at_start", 0,  -1, 1'b0, 0, 1'b1, 7'd5, 16'hA5A5);
`ifdef STREAMER_PAUSE_EN
        run_frame("pause",       4,  -1, 1'b0, 5, 1'b0, 7'd0, 16'h0);
`endif
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
